// File: rtl/down_counter_ctrl.sv
// Countdown sequencer: loads a start value, counts it down at a prescaled tick rate,
// and supports pause, abort and periodic auto-reload with a one-cycle expiry pulse.
module down_counter_ctrl #(
  parameter int WIDTH = 32,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             paused,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} st_t;

  localparam int            PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PSC_MAX = PW'(DIV - 1);

  st_t              state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             ar_q, ar_d;
  logic [PW-1:0]    psc_q, psc_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             paused_q, paused_d;

  logic load_ok, tick, expire;

  // Start is only honoured when not busy; abort outranks everything.
  assign load_ok = start && !abort && (state_q == IDLE || state_q == DONE);
  assign tick    = (state_q == RUN) && !abort && !pause && (psc_q == PSC_MAX);
  assign expire  = tick && (cnt_q == WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort)        state_d = IDLE;
    else if (load_ok) state_d = (load_val != '0) ? RUN : DONE;
    else begin
      case (state_q)
        RUN:     if (pause) state_d = PAUSE;
                 else if (expire && !ar_q) state_d = DONE;
        PAUSE:   if (!pause) state_d = RUN;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    reload_d = reload_q;
    ar_d     = ar_q;
    psc_d    = psc_q;
    done_d   = 1'b0;
    if (abort) begin
      cnt_d = '0;
      psc_d = '0;
    end else if (load_ok) begin
      psc_d = '0;
      if (load_val != '0) begin
        cnt_d    = load_val;
        reload_d = load_val;
        ar_d     = auto_reload;
      end else begin
        cnt_d  = '0;
        done_d = 1'b1;
      end
    end else if (state_q == RUN && !pause) begin
      psc_d = tick ? '0 : psc_q + 1'b1;
      if (expire) begin
        done_d = 1'b1;
        cnt_d  = ar_q ? reload_q : '0;
      end else if (tick) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
    busy_d   = (state_d == RUN) || (state_d == PAUSE);
    paused_d = (state_d == PAUSE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      reload_q <= '0;
      ar_q     <= 1'b0;
      psc_q    <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      ar_q     <= ar_d;
      psc_q    <= psc_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      paused_q <= paused_d;
    end
  end

  assign cnt    = cnt_q;
  assign busy   = busy_q;
  assign paused = paused_q;
  assign done   = done_q;
  assign state  = state_q;

endmodule

// File: tb/tb_down_counter_ctrl.sv
// Bench for down_counter_ctrl: two instances (DIV=1 and DIV=4) share stimulus and are
// compared every cycle against a cycle-level reference model, plus directed scenarios.
module tb_down_counter_ctrl;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, auto_reload = 1'b0, pause = 1'b0, abort = 1'b0;
  logic [W-1:0] load_val = '0;

  logic [W-1:0] cnt1, cnt4;
  logic busy1, busy4, paused1, paused4, done1, done4;
  logic [1:0] state1, state4;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  down_counter_ctrl #(.WIDTH(W), .DIV(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .load_val(load_val),
    .auto_reload(auto_reload), .pause(pause), .abort(abort),
    .cnt(cnt1), .busy(busy1), .paused(paused1), .done(done1), .state(state1));

  down_counter_ctrl #(.WIDTH(W), .DIV(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start), .load_val(load_val),
    .auto_reload(auto_reload), .pause(pause), .abort(abort),
    .cnt(cnt4), .busy(busy4), .paused(paused4), .done(done4), .state(state4));

  // Reference model, index 0 = DIV 1, index 1 = DIV 4. mode: 0 idle 1 run 2 paused 3 done
  int dv [2] = '{1, 4};
  int mm [2], mc [2], mr [2], ma [2], mp [2], md [2];

  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      mm[i] = 0; mc[i] = 0; mr[i] = 0; ma[i] = 0; mp[i] = 0; md[i] = 0;
    end
  endtask

  task automatic mstep(input int i);
    md[i] = 0;
    if (abort) begin
      mm[i] = 0; mc[i] = 0; mp[i] = 0;
    end else if (start && (mm[i] == 0 || mm[i] == 3)) begin
      mp[i] = 0;
      if (load_val != 0) begin
        mm[i] = 1; mc[i] = int'(load_val); mr[i] = int'(load_val); ma[i] = int'(auto_reload);
      end else begin
        mm[i] = 3; mc[i] = 0; md[i] = 1;
      end
    end else if (mm[i] == 1) begin
      if (pause) mm[i] = 2;
      else begin
        mp[i] = (mp[i] + 1) % dv[i];
        if (mp[i] == 0) begin
          if (mc[i] > 1) mc[i] = mc[i] - 1;
          else begin
            md[i] = 1;
            if (ma[i] != 0) mc[i] = mr[i];
            else begin mc[i] = 0; mm[i] = 3; end
          end
        end
      end
    end else if (mm[i] == 2) begin
      if (!pause) mm[i] = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cmp_all();
    chk("u1.cnt",    32'(cnt1),    32'(mc[0]));
    chk("u1.state",  32'(state1),  32'(mm[0]));
    chk("u1.done",   32'(done1),   32'(md[0]));
    chk("u1.busy",   32'(busy1),   32'(mm[0] == 1 || mm[0] == 2));
    chk("u1.paused", 32'(paused1), 32'(mm[0] == 2));
    chk("u4.cnt",    32'(cnt4),    32'(mc[1]));
    chk("u4.state",  32'(state4),  32'(mm[1]));
    chk("u4.done",   32'(done4),   32'(md[1]));
    chk("u4.busy",   32'(busy4),   32'(mm[1] == 1 || mm[1] == 2));
    chk("u4.paused", 32'(paused4), 32'(mm[1] == 2));
  endtask

  // One clock: model advances on the inputs seen at the edge, outputs checked 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    mstep(0); mstep(1);
    #1;
    cmp_all();
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic go(input int lv, input logic ar);
    load_val = W'(lv); auto_reload = ar; start = 1'b1;
  endtask

  initial begin
    int n;
    int seq3 [7] = '{3, 2, 1, 3, 2, 1, 3};
    mreset();
    #12;
    cmp_all();
    rst_n = 1'b1;
    cyc();

    // one-shot, load 5
    go(5, 1'b0); cyc();
    chk("oneshot.load", 32'(cnt1), 32'd5);
    for (int j = 0; j < 5; j++) begin
      cyc();
      chk("oneshot.cnt",  32'(cnt1),  32'(4 - j));
      chk("oneshot.done", 32'(done1), 32'(j == 4));
    end
    chk("oneshot.state", 32'(state1), 32'd3);

    // auto-reload, load 3, then abort mid-period
    go(3, 1'b1);
    for (int j = 0; j < 7; j++) begin
      cyc();
      chk("reload.cnt",  32'(cnt1),  32'(seq3[j]));
      chk("reload.done", 32'(done1), 32'(j == 3 || j == 6));
    end
    cyc();
    abort = 1'b1; cyc();
    chk("abort.cnt",   32'(cnt1),  32'd0);
    chk("abort.state", 32'(state1), 32'd0);
    chk("abort.done",  32'(done1), 32'd0);

    // pause at cnt 7: four cycles in PAUSE-or-resume, expiry 14 cycles after start
    go(10, 1'b0); cyc();
    n = 0;
    for (int j = 0; j < 3; j++) begin cyc(); n++; end
    chk("pause.pre", 32'(cnt1), 32'd7);
    pause = 1'b1;
    for (int j = 0; j < 3; j++) begin
      cyc(); n++;
      chk("pause.state",  32'(state1),  32'd2);
      chk("pause.paused", 32'(paused1), 32'd1);
      chk("pause.cnt",    32'(cnt1),    32'd7);
    end
    pause = 1'b0;
    cyc(); n++;
    chk("pause.resume", 32'(cnt1), 32'd7);
    while (!done1 && n < 40) begin cyc(); n++; end
    chk("pause.expiry_cycles", 32'(n), 32'd14);

    // zero load ignores auto_reload; restart from DONE
    go(0, 1'b1); cyc();
    chk("zero.done",  32'(done1),  32'd1);
    chk("zero.state", 32'(state1), 32'd3);
    cyc();
    chk("zero.noreload", 32'(cnt1), 32'd0);
    chk("zero.hold",     32'(done1), 32'd0);
    go(2, 1'b0); cyc();
    chk("restart.state", 32'(state1), 32'd1);
    chk("restart.cnt",   32'(cnt1),   32'd2);

    // start while running is ignored; abort beats start
    go(9, 1'b0); cyc();
    chk("busy_start.cnt", 32'(cnt1), 32'd1);
    abort = 1'b1; go(5, 1'b0); cyc();
    chk("abort_start.state", 32'(state1), 32'd0);
    chk("abort_start.cnt",   32'(cnt1),   32'd0);
    chk("abort_start.u4",    32'(state4), 32'd0);

    // prescaler DIV=4, load 2
    go(2, 1'b0); cyc();
    n = 0;
    while (!done4 && n < 40) begin
      cyc(); n++;
      if (n == 4) chk("div4.first_tick", 32'(cnt4), 32'd1);
    end
    chk("div4.expiry_cycles", 32'(n), 32'd8);

    // async reset between edges mid-count
    go(20, 1'b0); cyc();
    for (int j = 0; j < 5; j++) cyc();
    chk("areset.pre", 32'(cnt1), 32'd15);
    #2 rst_n = 1'b0;
    #1;
    mreset();
    chk("areset.cnt",   32'(cnt1),  32'd0);
    chk("areset.state", 32'(state1), 32'd0);
    chk("areset.busy",  32'(busy1), 32'd0);
    #1 rst_n = 1'b1;
    cyc();

    // randomized traffic against the model
    for (int j = 0; j < 400; j++) begin
      @(negedge clk);
      start       = ($urandom % 6) == 0;
      abort       = ($urandom % 25) == 0;
      pause       = ($urandom % 5) == 0;
      auto_reload = $urandom % 2;
      load_val    = W'($urandom_range(0, 6));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
